// File: rtl/ts_injection_slot_scheduler.sv
// Time-slot injection scheduler: walks a dual-port slot table once per slot boundary and
// queues valid entries' flow IDs into a small show-ahead FIFO with overflow counting.
module ts_injection_slot_scheduler #(
    parameter int unsigned TABLE_DEPTH = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned FLOW_W      = 5,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sched_en,
    input  logic [63:0]       iv_syn_clk,
    input  logic [5:0]        iv_slot_shift,
    input  logic [ADDR_W:0]   iv_table_period,
    input  logic [ADDR_W-1:0] iv_cfg_addr,
    input  logic [FLOW_W:0]   iv_cfg_wdata,
    input  logic              i_cfg_wr,
    input  logic              i_cfg_rd,
    output logic [FLOW_W:0]   ov_cfg_rdata,
    output logic              o_cfg_rdata_valid,
    output logic [FLOW_W-1:0] ov_ts_injection_addr,
    output logic              o_ts_injection_addr_wr,
    input  logic              i_ts_injection_addr_ack,
    output logic [ADDR_W-1:0] ov_slot_ptr,
    output logic [15:0]       ov_overflow_cnt
);
    localparam int unsigned FptrW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRd, StWait, StPush} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   slot_ptr_q, slot_ptr_d;
    logic [ADDR_W:0]     ptr_inc;
    logic                slot_bit_q;
    logic                boundary;
    logic                push_req;
    logic [FLOW_W:0]     entry_q;

    logic [FLOW_W:0]     table_mem [TABLE_DEPTH];
    logic [FLOW_W:0]     rd_a_q, rd_b_q;
    logic                rd_pend_q;
    logic                cfg_valid_q;
    logic [FLOW_W:0]     cfg_rdata_q;

    logic [FLOW_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FptrW-1:0]    wptr_q, rptr_q;
    logic [FptrW:0]      cnt_q, cnt_d;
    logic                fifo_full, fifo_push, fifo_pop, fifo_drop;
    logic [15:0]         ovf_q;

    // Table RAM: no reset. Both reads are read-before-write, so a same-cycle write
    // to the entry under scan leaves the scheduler with the old data.
    always_ff @(posedge i_clk) begin
        if (i_cfg_wr) begin
            table_mem[iv_cfg_addr] <= iv_cfg_wdata;
        end
        rd_a_q <= table_mem[iv_cfg_addr];
        rd_b_q <= table_mem[slot_ptr_q];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_rdata_q <= '0;
        end else begin
            rd_pend_q   <= i_cfg_rd & ~i_cfg_wr;
            cfg_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                cfg_rdata_q <= rd_a_q;
            end
        end
    end

    assign boundary = (iv_syn_clk[iv_slot_shift] != slot_bit_q) && i_sched_en &&
                      (iv_table_period != '0);
    assign ptr_inc  = {1'b0, slot_ptr_q} + (ADDR_W + 1)'(1);

    always_comb begin
        state_d    = state_q;
        slot_ptr_d = slot_ptr_q;
        push_req   = 1'b0;
        if (!i_sched_en) begin
            state_d    = StIdle;
            slot_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle: if (boundary) state_d = StRd;
                StRd:   state_d = StWait;
                StWait: state_d = StPush;
                StPush: begin
                    state_d    = StIdle;
                    push_req   = entry_q[FLOW_W];
                    slot_ptr_d = (ptr_inc >= iv_table_period) ? '0 : ptr_inc[ADDR_W-1:0];
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            slot_ptr_q <= '0;
            slot_bit_q <= 1'b0;
            entry_q    <= '0;
        end else begin
            state_q    <= state_d;
            slot_ptr_q <= slot_ptr_d;
            slot_bit_q <= iv_syn_clk[iv_slot_shift];
            if (state_q == StWait) begin
                entry_q <= rd_b_q;
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign fifo_full = (cnt_q == (FptrW + 1)'(FIFO_DEPTH));
    assign fifo_pop  = (cnt_q != '0) && i_ts_injection_addr_ack;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign fifo_drop = push_req && fifo_full && !fifo_pop;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + (FptrW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (FptrW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) begin
            fifo_mem[wptr_q] <= entry_q[FLOW_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (fifo_push) begin
                wptr_q <= wptr_q + FptrW'(1);
            end
            if (fifo_pop) begin
                rptr_q <= rptr_q + FptrW'(1);
            end
            if (fifo_drop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    // Head is masked while empty so the data output reads 0 out of reset.
    assign ov_ts_injection_addr   = (cnt_q != '0) ? fifo_mem[rptr_q] : '0;
    assign o_ts_injection_addr_wr = (cnt_q != '0);
    assign ov_slot_ptr            = slot_ptr_q;
    assign ov_overflow_cnt        = ovf_q;
    assign ov_cfg_rdata           = cfg_rdata_q;
    assign o_cfg_rdata_valid      = cfg_valid_q;

endmodule

// File: tb/tb_ts_injection_slot_scheduler.sv
// Scoreboard bench: a slot-level reference model predicts injected flow IDs, drops and
// config read data; a negedge monitor compares them against the scheduler's outputs.
module tb_ts_injection_slot_scheduler;
    localparam int unsigned TD = 1024;
    localparam int unsigned AW = 10;
    localparam int unsigned FW = 5;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [63:0]   syn = 64'd0;
    logic [5:0]    shift = 6'd10;
    logic [AW:0]   period = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [FW:0]   cfg_wdata = '0;
    logic          cfg_wr = 1'b0;
    logic          cfg_rd = 1'b0;
    logic          ack = 1'b0;
    logic [FW:0]   cfg_rdata;
    logic          cfg_valid;
    logic [FW-1:0] inj_addr;
    logic          inj_wr;
    logic [AW-1:0] slot_ptr;
    logic [15:0]   ovf;

    ts_injection_slot_scheduler #(
        .TABLE_DEPTH(TD), .ADDR_W(AW), .FLOW_W(FW), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_sched_en             (en),
        .iv_syn_clk             (syn),
        .iv_slot_shift          (shift),
        .iv_table_period        (period),
        .iv_cfg_addr            (cfg_addr),
        .iv_cfg_wdata           (cfg_wdata),
        .i_cfg_wr               (cfg_wr),
        .i_cfg_rd               (cfg_rd),
        .ov_cfg_rdata           (cfg_rdata),
        .o_cfg_rdata_valid      (cfg_valid),
        .ov_ts_injection_addr   (inj_addr),
        .o_ts_injection_addr_wr (inj_wr),
        .i_ts_injection_addr_ack(ack),
        .ov_slot_ptr            (slot_ptr),
        .ov_overflow_cnt        (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 60) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;
    // Global time ramps 1 ns per clock.
    always @(posedge clk) begin
        #1;
        syn = syn + 64'd1;
    end

    // ---------------- reference model ----------------
    typedef struct { int c; logic [FW:0] d; } cfg_exp_t;
    logic [FW:0]   tbl [8];
    logic [FW-1:0] exp_q [$];
    cfg_exp_t      cfg_q [$];
    cfg_exp_t      ce;
    logic          m_bit, m_slot_bit;
    bit            m_job, m_bnd, m_push, m_pop;
    int            m_age, m_ptr, m_occ, m_drop, m_pushes;
    logic [FW:0]   m_entry;

    // One boundary starts a job: the entry at the pointer is read a cycle later and its
    // flow ID enters the FIFO three edges after the boundary edge; the pointer then moves on.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bit = 1'b0; m_job = 0; m_age = 0; m_ptr = 0; m_occ = 0; m_drop = 0;
            m_pushes = 0; m_entry = '0;
            exp_q.delete();
            cfg_q.delete();
        end else begin
            m_slot_bit = syn[shift];
            m_bnd  = (m_slot_bit != m_bit) && en && (period != 0);
            m_bit  = m_slot_bit;
            m_pop  = (m_occ > 0) && ack;
            m_push = 0;
            if (!en) begin
                m_job = 0;
                m_ptr = 0;
            end else if (m_job) begin
                m_age++;
                if (m_age == 1) m_entry = tbl[m_ptr];
                if (m_age == 3) begin
                    m_push = m_entry[FW];
                    m_ptr  = (m_ptr + 1 >= int'(period)) ? 0 : m_ptr + 1;
                    m_job  = 0;
                end
            end else if (m_bnd) begin
                m_job = 1;
                m_age = 0;
            end
            if (m_pop) m_occ--;
            if (m_push) begin
                m_pushes++;
                if (m_occ < int'(FD)) begin
                    m_occ++;
                    exp_q.push_back(m_entry[FW-1:0]);
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit cfg_exp_valid;
    always @(negedge clk) begin
        chk("inj_valid", inj_wr, m_occ > 0);
        if (inj_wr && exp_q.size() > 0) begin
            chk("inj_addr", inj_addr, exp_q[0]);
            if (ack) void'(exp_q.pop_front());
        end
        chk("slot_ptr", slot_ptr, m_ptr);
        chk("overflow_cnt", ovf, m_drop);
        while (cfg_q.size() > 0 && cfg_q[0].c < cyc) void'(cfg_q.pop_front());
        cfg_exp_valid = (cfg_q.size() > 0) && (cfg_q[0].c == cyc);
        chk("cfg_rdata_valid", cfg_valid, cfg_exp_valid);
        if (cfg_exp_valid) begin
            ce = cfg_q.pop_front();
            chk("cfg_rdata", cfg_rdata, ce.d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input logic [FW:0] d);
        cfg_addr = AW'(a); cfg_wdata = d; cfg_wr = 1'b1; tbl[a] = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic cfg_read(input int a);
        cfg_addr = AW'(a); cfg_rd = 1'b1;
        cfg_q.push_back('{cyc + 2, tbl[a]});
        tick();
        cfg_rd = 1'b0;
    endtask

    task automatic cfg_write_read(input int a, input logic [FW:0] d);
        cfg_addr = AW'(a); cfg_wdata = d; cfg_wr = 1'b1; cfg_rd = 1'b1; tbl[a] = d;
        tick();
        cfg_wr = 1'b0; cfg_rd = 1'b0;
    endtask

    int t;
    int d0;

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_inj_wr", inj_wr, 0);
        chk("rst_inj_addr", inj_addr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        rst_n = 1'b1;
        tick();

        // Table setup and config port checks
        cfg_write(0, 6'h27); cfg_write(1, 6'h23); cfg_write(2, 6'h0C); cfg_write(3, 6'h29);
        for (int a = 4; a < 8; a++) cfg_write(a, 6'h00);
        cfg_write(5, 6'h2A);
        cfg_read(5);
        repeat (3) tick();
        cfg_write_read(6, 6'h15);
        repeat (3) tick();
        cfg_read(6);
        repeat (3) tick();

        // Basic scan: 1024-ns slots, ack held high
        shift = 6'd10; period = 11'd4; ack = 1'b1;
        tick();
        en = 1'b1;
        repeat (5200) tick();

        // Consumer stalls for six valid slots
        en = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        cfg_write(2, 6'h35);
        shift = 6'd4; ack = 1'b0;
        tick();
        en = 1'b1;
        t = 0;
        while (m_pushes < 6 && t < 2000) begin tick(); t++; end
        chk("stall_wait_done", t < 2000, 1);
        chk("stall_ovf", ovf, 2);
        chk("stall_wr_held", inj_wr, 1);
        chk("stall_head", inj_addr, 7);
        ack = 1'b1;
        repeat (40) tick();

        // Full FIFO, pop in the same cycle as a push
        ack = 1'b0;
        t = 0;
        while (!(m_occ == int'(FD) && m_job && m_age == 2 && m_entry[FW]) && t < 2000) begin
            tick(); t++;
        end
        chk("full_push_wait_done", t < 2000, 1);
        d0 = m_drop;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("full_push_no_drop", ovf, d0);
        chk("full_push_still_valid", inj_wr, 1);
        ack = 1'b1;
        repeat (40) tick();

        // Randomised rounds
        for (int r = 0; r < 6; r++) begin
            en = 1'b0;
            tick();
            for (int a = 0; a < 8; a++) cfg_write(a, 6'($urandom));
            shift  = 6'($urandom_range(5, 3));
            period = (AW + 1)'($urandom_range(6, 0));
            repeat (2) tick();
            en = 1'b1;
            for (int k = 0; k < 600; k++) begin
                ack = ($urandom_range(3, 0) != 0);
                if ($urandom_range(63, 0) == 0) period = (AW + 1)'($urandom_range(6, 0));
                en = ($urandom_range(199, 0) != 0);
                tick();
            end
        end

        // Abort in the read-latency state with pointer 2
        en = 1'b0;
        tick();
        cfg_write(0, 6'h31); cfg_write(1, 6'h32); cfg_write(2, 6'h33); cfg_write(3, 6'h34);
        shift = 6'd4; period = 11'd4; ack = 1'b1;
        repeat (2) tick();
        en = 1'b1;
        t = 0;
        while (!(m_job && m_age == 1 && m_ptr == 2) && t < 2000) begin tick(); t++; end
        chk("abort_wait_done", t < 2000, 1);
        en = 1'b0;
        tick();
        chk("abort_ptr_zero", slot_ptr, 0);
        repeat (3) tick();
        chk("abort_no_push", inj_wr, 0);
        en = 1'b1;
        t = 0;
        while (!inj_wr && t < 200) begin tick(); t++; end
        chk("reenable_wait_done", t < 200, 1);
        chk("reenable_first_entry", inj_addr, 5'h11);

        // Reset with a partly full FIFO and five drops
        ack = 1'b0;
        t = 0;
        while (!(m_drop >= 5 && !m_job) && t < 3000) begin tick(); t++; end
        chk("drop5_wait_done", t < 3000, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("pre_reset_ovf", ovf, 5);
        chk("pre_reset_wr", inj_wr, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_inj_wr", inj_wr, 0);
        chk("async_rst_inj_addr", inj_addr, 0);
        chk("async_rst_ptr", slot_ptr, 0);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_cfg_valid", cfg_valid, 0);
        chk("async_rst_cfg_rdata", cfg_rdata, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            cfg_read(a);
            tick();
        end
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ts_injection_slot_scheduler.md
# ts_injection_slot_scheduler

Parametrised time-slot injection scheduler for the host-input path of the TSN end device. It tracks the global synchronised clock, and at each slot boundary reads one entry of a configurable injection slot table. For each valid entry it queues the entry's flow buffer address to the TS injection management stage through a small output FIFO. Compared with the fixed scheduler, table depth, flow-ID width and FIFO depth are parameters, slot length is a power-of-two shift, and handshake overruns are buffered and counted.

## Interface
- `TABLE_DEPTH`, 1024: number of slot-table entries (power of two).
- `ADDR_W`, 10: log2(`TABLE_DEPTH`).
- `FLOW_W`, 5: width of the injection address / flow buffer ID.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `i_clk`  in  1  sole clock.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_sched_en`  in  1  scheduler enable (hardware stage = running).
- `iv_syn_clk`  in  64  synchronised global time, ns.
- `iv_slot_shift`  in  6  slot length = 2^`iv_slot_shift` ns; slot bit = `iv_syn_clk[iv_slot_shift]`.
- `iv_table_period`  in  `ADDR_W`+1  active entries, 1..`TABLE_DEPTH`; 0 means no injection.
- `iv_cfg_addr`  in  `ADDR_W`  table config address.
- `iv_cfg_wdata`  in  `FLOW_W`+1  entry: bit `FLOW_W` = valid, `[FLOW_W-1:0]` = flow ID.
- `i_cfg_wr`  in  1  table write strobe.
- `i_cfg_rd`  in  1  table read strobe.
- `ov_cfg_rdata`  out  `FLOW_W`+1  read data.
- `o_cfg_rdata_valid`  out  1  one-cycle pulse, read data valid.
- `ov_ts_injection_addr`  out  `FLOW_W`  FIFO head flow ID.
- `o_ts_injection_addr_wr`  out  1  FIFO non-empty (valid).
- `i_ts_injection_addr_ack`  in  1  consumer accept.
- `ov_slot_ptr`  out  `ADDR_W`  next table entry to be read.
- `ov_overflow_cnt`  out  16  dropped-entry count, saturating.

## Operation
- The table is a dual-port RAM. Port A serves config; port B is the scheduler's read-only port. Table contents are not cleared by reset.
- Config write: the entry is written at the edge where `i_cfg_wr` is sampled.
- Config read: `ov_cfg_rdata` and `o_cfg_rdata_valid` appear 2 cycles after `i_cfg_rd`.
- If `i_cfg_wr` and `i_cfg_rd` are both asserted, the write takes priority and the read is ignored.
- Boundary detect: the register `slot_bit_q` samples `iv_syn_clk[iv_slot_shift]` every cycle. A boundary occurs when the sampled bit differs from `slot_bit_q` while `i_sched_en` = 1 and `iv_table_period` ≠ 0.
- FSM states: IDLE, RD, WAIT, PUSH.
  - IDLE → RD on a boundary. RD drives the port-B address = `slot_ptr`.
  - RD → WAIT: one cycle of RAM latency.
  - WAIT → PUSH: the entry is captured. If its valid bit is set, a push is requested.
  - PUSH → IDLE. In the same cycle, `slot_ptr` ← `slot_ptr`+1, or 0 if `slot_ptr`+1 ≥ `iv_table_period`.
- A boundary arriving while not in IDLE is ignored. Slot length must be ≥ 8 clock cycles; a shorter slot is a configuration error.
- Push with the FIFO full: the entry is dropped and `ov_overflow_cnt` increments, saturating at 0xFFFF.
- Push and pop in the same cycle with the FIFO full: the push is accepted, with no drop.
- Pop occurs when `o_ts_injection_addr_wr` && `i_ts_injection_addr_ack`. The output is a show-ahead FIFO head and stays stable until acked.
- `i_sched_en` low:
  - The FSM aborts to IDLE without pushing, and `slot_ptr` ← 0.
  - The FIFO keeps its contents and continues to drain.
  - `slot_bit_q` keeps tracking, so no spurious boundary occurs on re-enable.
- `iv_table_period` reduced below `slot_ptr`: the pointer wraps to 0 at the next PUSH.
- Config write to the entry being read on port B in the same cycle: the scheduler gets the old data.

## Timing
- Reset values:
  - all outputs 0;
  - `slot_ptr` 0; FSM IDLE; FIFO empty;
  - `slot_bit_q` 0; `ov_overflow_cnt` 0.
- Edge E0 is the first rising edge that samples the toggled slot bit.
  - The FSM is in RD after E0, WAIT after E1, PUSH after E2.
  - With an empty FIFO, `o_ts_injection_addr_wr` goes high after E3.
- Throughput: one entry per slot. The consumer may hold off ack indefinitely; buffering is `FIFO_DEPTH` slots.
- Reset asserted mid-operation clears everything immediately, including FIFO contents.

## Test plan
- Table entries 0..3 = {1,7},{1,3},{0,x},{1,9}; period 4; shift 10; ack tied high; syn_clk ramps 1 ns/cycle.
  - Injection addrs 7, 3, 9, 7, … appear at 1024-ns boundaries, each 4 edges after the bit toggle.
  - Entry 2 produces nothing. `ov_slot_ptr` wraps 3→0.
- Ack held low for 6 slots of valid entries with `FIFO_DEPTH`=4.
  - `o_ts_injection_addr_wr` stays high with the first addr stable.
  - `ov_overflow_cnt` = 2; the four oldest addrs drain in order once ack rises.
- FIFO full, ack asserted in the same cycle as a PUSH.
  - No drop; the count stays at 4; `ov_overflow_cnt` unchanged.
- Config write of 0x2A to addr 5, then read of addr 5.
  - `o_cfg_rdata_valid` pulses 2 cycles later with data 0x2A.
  - Simultaneous wr and rd to the same address: the read is ignored.
- Deassert `i_sched_en` in WAIT with `slot_ptr`=2.
  - No push occurs; `ov_slot_ptr` = 0.
  - After re-enable, the first boundary injects entry 0.
- Assert reset with 3 FIFO entries and `ov_overflow_cnt`=5.
  - All outputs are 0 in the same cycle.
  - After release, the table still holds the prior contents: config read returns them.
